// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Combinational helpers only; no latency or flow control of its own.
package arb_pkg;

   localparam int MAX_PORTS = 32;

   typedef enum logic {IDLE, GRANTED} arb_state_t;

   // Priority mask after granting idx: lower-priority side of idx only, so the
   // just-served port and everything ahead of it lose until the mask empties.
   function automatic logic [MAX_PORTS-1:0] rr_mask(input int idx, input logic lsb_high,
                                                   input int ports);
      logic [MAX_PORTS-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         if (i < ports && (lsb_high ? (i > idx) : (i < idx))) begin
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: valid, binary index and one-hot of the winning bit.
// Zero latency; no flow control, the caller samples the result.
module priority_encoder #(
   parameter int WIDTH             = 4,
   parameter int LSB_HIGH_PRIORITY = 0,
   localparam int IDX_W            = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] input_unencoded,
   output logic             output_valid,
   output logic [IDX_W-1:0] output_encoded,
   output logic [WIDTH-1:0] output_unencoded
);

   always_comb begin
      output_valid     = |input_unencoded;
      output_encoded   = '0;
      output_unencoded = '0;
      if (LSB_HIGH_PRIORITY != 0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (input_unencoded[i]) output_encoded = IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (input_unencoded[i]) output_encoded = IDX_W'(i);
         end
      end
      if (output_valid) output_unencoded[output_encoded] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter: one-hot grant one edge after request, priority rotates per new grant.
// Backpressure: optional grant lock until the winner drops its request or acknowledges.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int PORTS             = 4,
   parameter int ARB_BLOCK         = 0,
   parameter int ARB_BLOCK_ACK     = 0,
   parameter int LSB_HIGH_PRIORITY = 0,
   localparam int IDX_W            = $clog2(PORTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] request,
   input  logic [PORTS-1:0] acknowledge,
   output logic [PORTS-1:0] grant,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_encoded
);

   arb_state_t           state;
   logic [PORTS-1:0]     mask;
   logic [PORTS-1:0]     masked_req;
   logic                 m_valid;
   logic [IDX_W-1:0]     m_enc;
   logic [PORTS-1:0]     m_onehot;
   logic                 r_valid;
   logic [IDX_W-1:0]     r_enc;
   logic [PORTS-1:0]     r_onehot;
   logic [IDX_W-1:0]     win_idx;
   logic [PORTS-1:0]     win_onehot;
   logic                 release_now;
   logic [MAX_PORTS-1:0] mask_full;
   logic                 unused_mask_hi;

   assign masked_req = request & mask;

   priority_encoder #(
      .WIDTH             (PORTS),
      .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
   ) u_pe_masked (
      .input_unencoded  (masked_req),
      .output_valid     (m_valid),
      .output_encoded   (m_enc),
      .output_unencoded (m_onehot)
   );

   priority_encoder #(
      .WIDTH             (PORTS),
      .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
   ) u_pe_raw (
      .input_unencoded  (request),
      .output_valid     (r_valid),
      .output_encoded   (r_enc),
      .output_unencoded (r_onehot)
   );

   always_comb begin
      win_idx    = m_valid ? m_enc : r_enc;
      win_onehot = m_valid ? m_onehot : r_onehot;
      mask_full  = rr_mask(int'(win_idx), LSB_HIGH_PRIORITY != 0, PORTS);
      // A held grant only yields on its own request/ack bit; everything else is ignored.
      if (state == IDLE || ARB_BLOCK == 0) begin
         release_now = 1'b1;
      end else if (ARB_BLOCK_ACK != 0) begin
         release_now = acknowledge[grant_encoded];
      end else begin
         release_now = !request[grant_encoded];
      end
   end

   assign unused_mask_hi = ^mask_full;
   assign grant_valid    = (state == GRANTED);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         grant         <= '0;
         grant_encoded <= '0;
         mask          <= '1;
      end else if (release_now) begin
         if (r_valid) begin
            state         <= GRANTED;
            grant         <= win_onehot;
            grant_encoded <= win_idx;
            mask          <= mask_full[PORTS-1:0];
         end else begin
            state         <= IDLE;
            grant         <= '0;
            grant_encoded <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed vector table plus random invariant run over four arbiter configurations.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] request;
   logic [3:0] acknowledge;
   logic [3:0] gnt  [4];
   logic       gv   [4];
   logic [1:0] genc [4];

   always #5 clk = ~clk;

   // d0: re-arbitrate, MSB wins; d1: re-arbitrate, LSB wins; d2: request lock; d3: ack lock
   rr_arbiter #(.PORTS(4), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(0)) u_d0 (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(gnt[0]), .grant_valid(gv[0]), .grant_encoded(genc[0]));
   rr_arbiter #(.PORTS(4), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1)) u_d1 (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(gnt[1]), .grant_valid(gv[1]), .grant_encoded(genc[1]));
   rr_arbiter #(.PORTS(4), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(0)) u_d2 (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(gnt[2]), .grant_valid(gv[2]), .grant_encoded(genc[2]));
   rr_arbiter #(.PORTS(4), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(0)) u_d3 (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(gnt[3]), .grant_valid(gv[3]), .grant_encoded(genc[3]));

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] ack;
      int         dut;
      logic [3:0] gnt;
      logic [1:0] enc;
      string      name;
   } vec_t;

   vec_t       vecs[$];
   int         checks = 0;
   int         errors = 0;
   int         wait_cnt[4];
   logic [3:0] prev_req;

   function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] ak,
                               input int d, input logic [3:0] g, input logic [1:0] e,
                               input string n);
      vec_t v;
      v.rst = r; v.req = rq; v.ack = ak; v.dut = d; v.gnt = g; v.enc = e; v.name = n;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [3:0] g_act, input logic [1:0] e_act,
                        input logic v_act, input logic [3:0] g_exp, input logic [1:0] e_exp);
      logic v_exp;
      v_exp = (g_exp != 4'b0000);
      checks++;
      if (g_act !== g_exp || e_act !== e_exp || v_act !== v_exp) begin
         errors++;
         $display("FAIL %s: grant=%b enc=%0d valid=%b, expected grant=%b enc=%0d valid=%b",
                  name, g_act, e_act, v_act, g_exp, e_exp, v_exp);
      end
   endtask

   initial begin
      // Reset hold then MSB-first rotation, then a lone requester
      repeat (3) add(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, "rst_hold");
      add(0, 4'b1111, 4'b0000, 0, 4'b1000, 3, "rst_release");
      add(0, 4'b1111, 4'b0000, 0, 4'b0100, 2, "rot_msb_1");
      add(0, 4'b1111, 4'b0000, 0, 4'b0010, 1, "rot_msb_2");
      add(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, "rot_msb_3");
      add(0, 4'b1111, 4'b0000, 0, 4'b1000, 3, "rot_msb_wrap");
      repeat (3) add(0, 4'b0001, 4'b0000, 0, 4'b0001, 0, "single_req");
      // LSB-first rotation
      add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, "rst_lsb");
      add(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, "rot_lsb_0");
      add(0, 4'b1111, 4'b0000, 1, 4'b0010, 1, "rot_lsb_1");
      add(0, 4'b1111, 4'b0000, 1, 4'b0100, 2, "rot_lsb_2");
      add(0, 4'b1111, 4'b0000, 1, 4'b1000, 3, "rot_lsb_3");
      add(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, "rot_lsb_wrap");
      // Request-held lock
      add(1, 4'b0000, 4'b0000, 2, 4'b0000, 0, "rst_hold_mode");
      add(0, 4'b1010, 4'b0000, 2, 4'b1000, 3, "hold_grant");
      repeat (5) add(0, 4'b1010, 4'b0000, 2, 4'b1000, 3, "hold_keep");
      add(0, 4'b0010, 4'b0000, 2, 4'b0010, 1, "hold_drop3");
      add(0, 4'b0000, 4'b0000, 2, 4'b0000, 0, "hold_idle");
      // Acknowledge lock
      add(1, 4'b0000, 4'b0000, 3, 4'b0000, 0, "rst_ack_mode");
      add(0, 4'b0110, 4'b0000, 3, 4'b0100, 2, "ack_grant");
      add(0, 4'b0010, 4'b0000, 3, 4'b0100, 2, "ack_req_drop");
      add(0, 4'b0010, 4'b0010, 3, 4'b0100, 2, "ack_wrong_bit");
      add(0, 4'b0010, 4'b0100, 3, 4'b0010, 1, "ack_release");
      add(0, 4'b0010, 4'b0000, 3, 4'b0010, 1, "ack_hold2");
      add(0, 4'b0010, 4'b0010, 3, 4'b0010, 1, "ack_regrant_raw");
      add(0, 4'b0000, 4'b0000, 3, 4'b0010, 1, "ack_hold_noreq");
      add(0, 4'b0000, 4'b0010, 3, 4'b0000, 0, "ack_to_idle");
      add(0, 4'b0000, 4'b1111, 3, 4'b0000, 0, "ack_idle_ignored");
      // Reset in the middle of a locked grant must restore the all-ones mask
      add(1, 4'b0000, 4'b0000, 2, 4'b0000, 0, "rst_midgrant");
      add(0, 4'b0110, 4'b0000, 2, 4'b0100, 2, "mr_grant");
      add(0, 4'b0110, 4'b0000, 2, 4'b0100, 2, "mr_hold");
      add(1, 4'b0110, 4'b0000, 2, 4'b0000, 0, "mr_in_reset");
      add(0, 4'b0110, 4'b0000, 2, 4'b0100, 2, "mr_after_reset");

      rst = 1'b1;
      request = '0;
      acknowledge = '0;
      repeat (2) @(posedge clk);

      foreach (vecs[k]) begin
         @(negedge clk);
         rst         = vecs[k].rst;
         request     = vecs[k].req;
         acknowledge = vecs[k].ack;
         @(posedge clk);
         #1;
         check(vecs[k].name, gnt[vecs[k].dut], genc[vecs[k].dut], gv[vecs[k].dut],
               vecs[k].gnt, vecs[k].enc);
      end

      // Random run: shape invariants on every config, latency and fairness on d0
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int p = 0; p < 4; p++) wait_cnt[p] = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         request     = 4'($urandom_range(0, 15));
         acknowledge = 4'($urandom_range(0, 15));
         prev_req    = request;
         @(posedge clk);
         #1;
         for (int d = 0; d < 4; d++) begin
            checks++;
            if (!$onehot0(gnt[d]) || gv[d] !== (gnt[d] != 4'b0000) ||
                (gnt[d] != 4'b0000 && gnt[d] != (4'b0001 << genc[d])) ||
                (gnt[d] == 4'b0000 && genc[d] != 2'd0)) begin
               errors++;
               $display("FAIL rand_shape dut%0d cycle %0d: grant=%b enc=%0d valid=%b, expected one-hot grant matching enc and valid",
                        d, c, gnt[d], genc[d], gv[d]);
            end
         end
         checks++;
         if (gv[0] !== (prev_req != 4'b0000) || (gnt[0] & ~prev_req) != 4'b0000) begin
            errors++;
            $display("FAIL rand_latency cycle %0d: grant=%b valid=%b, expected a bit of request=%b",
                     c, gnt[0], gv[0], prev_req);
         end
         for (int p = 0; p < 4; p++) begin
            if (prev_req[p] && !gnt[0][p]) begin
               wait_cnt[p]++;
               checks++;
               if (wait_cnt[p] > 3) begin
                  errors++;
                  $display("FAIL rand_starve port %0d cycle %0d: waited %0d grants, expected at most 3",
                           p, c, wait_cnt[p]);
               end
            end else begin
               wait_cnt[p] = 0;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
